flag_branch_unit: RTL and testbench
===================================

Name: flag_branch_unit

Overview:
- Consumer side of the 16-bit ALU.
- Captures the Z/V/N condition flags from each ALU result according to opcode rules, holds them in a flag register, and resolves conditional branches against them.
- Sits between the execute stage (ALU output) and fetch/PC logic.
- Produces a registered taken/not-taken decision one cycle after a branch is presented.

Parameters:
- DATA_W, 16, width of the ALU result used for Z/N derivation.
- OP_W, 4, width of the opcode field.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- alu_valid  input  1  ALU result this cycle is architectural.
- alu_op  input  4  opcode of the instruction producing alu_out.
- alu_out  input  DATA_W  ALU result.
- alu_ovfl  input  1  ALU overflow indication.
- stall  input  1  pipeline stall; freeze all state.
- flush  input  1  squash the current instruction and branch.
- br_valid  input  1  conditional branch present this cycle.
- br_cond  input  3  branch condition code.
- flags  output  3  registered flags {Z,V,N}, bit2 = Z, bit1 = V, bit0 = N.
- br_taken  output  1  registered branch decision.
- br_resolved  output  1  one-cycle pulse: br_taken is valid this cycle.

Behaviour:
- Reset (async, rst_n low): flags = 3'b000, br_taken = 0, br_resolved = 0. Release is synchronous to the next clk edge.
- Flag derivation:
  - Z = (alu_out == 0)
  - N = alu_out[DATA_W-1]
  - V = alu_ovfl
- Flag update mask by alu_op:
  - 0000 ADD, 0001 SUB: write Z, V, N.
  - 0010 XOR, 0100 SLL, 0101 SRA, 0110 ROR: write Z only; V and N hold.
  - All other opcodes (RED 0011, PADDSB 0111, 1xxx): no flag write.
- Flag write occurs on a rising edge when alu_valid & !stall & !flush and the mask is non-zero.
- Condition codes (evaluated against the flag source below):
  - 000 NE: !Z
  - 001 EQ: Z
  - 010 GT: !Z & !N
  - 011 LT: N
  - 100 GE: Z | (!Z & !N)
  - 101 LE: N | Z
  - 110 OV: V
  - 111 UN: 1
- Branch timing: when br_valid & !stall & !flush at edge k, br_taken is loaded and br_resolved = 1 for the cycle after edge k. br_resolved returns to 0 at edge k+1 unless a new branch is accepted.
- If no branch is accepted at an edge, br_resolved = 0 and br_taken holds its last value.
- stall high: flags, br_taken hold; br_resolved forced 0 at that edge; br_valid/alu_valid are ignored, and upstream re-presents them.
- flush high: dominates stall and valid. No flag write, br_resolved = 0, br_taken cleared to 0.
- Simultaneous alu_valid and br_valid (no bypass): the branch evaluates against the flags register value before this edge's update. The flag update still happens.
- Back-to-back flag writers: the last one wins; masked bits retain the older values.
- Reset mid-branch: the pending resolution is lost; br_resolved = 0 immediately.

Optional Feature:
- Macro FLAG_BYPASS_EN.
- Defined: when alu_valid and br_valid are both accepted in the same cycle, the condition is evaluated on the next-state flags, i.e. masked new bits merged with held bits. This removes the one-instruction flag hazard.
- Undefined: behaviour exactly as in Behaviour, with the branch seeing the old flags. The pipeline must insert a bubble for dependent branches.
- Latency of br_resolved is unchanged in both builds.

Decomposition:
- Shared package (wisc_pkg): opcode constants (OP_ADD … OP_PADDSB), condition-code constants (CC_NE … CC_UN), flag bit indices (FLG_Z, FLG_V, FLG_N), and the flags width.
- One natural sub-module: cond_eval. It is combinational, takes 3-bit cond and 3-bit flags, and outputs 1-bit taken. It is instantiated once in flag_branch_unit.

Test Plan:
- Reset, then ADD result 16'h0000 with ovfl 0, alu_valid 1 -> flags = 3'b100 next cycle. Then br_cond EQ -> br_taken 1, br_resolved pulse 1 cycle.
- SUB result 16'h8000 with ovfl 1 -> flags 3'b011. Then XOR result 16'h0000 -> flags 3'b111, with V and N held. Branches LT -> 1, OV -> 1, GT -> 0.
- RED then PADDSB results of 16'h0000 with flags 3'b011 -> flags unchanged 3'b011.
- stall held 2 cycles with alu_valid, br_valid high -> flags, br_taken unchanged, br_resolved 0. Then flush with br_valid -> br_taken 0, br_resolved 0, no flag write.
- Same-cycle ADD 16'h0000 plus br EQ from flags 3'b000 -> br_taken 0 without FLAG_BYPASS_EN, br_taken 1 with FLAG_BYPASS_EN. Flags = 3'b100 in both builds.
- Assert rst_n low mid-cycle after a branch is accepted -> br_resolved, br_taken, flags 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/wisc_pkg.sv
// Shared definitions for the flag/branch path: opcodes, condition codes,
// flag bit positions and the per-opcode flag write mask.
package wisc_pkg;

  localparam int FLAGS_W = 3;
  localparam int FLG_N   = 0;
  localparam int FLG_V   = 1;
  localparam int FLG_Z   = 2;

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_XOR    = 4'b0010;
  localparam logic [3:0] OP_RED    = 4'b0011;
  localparam logic [3:0] OP_SLL    = 4'b0100;
  localparam logic [3:0] OP_SRA    = 4'b0101;
  localparam logic [3:0] OP_ROR    = 4'b0110;
  localparam logic [3:0] OP_PADDSB = 4'b0111;

  localparam logic [2:0] CC_NE = 3'b000;
  localparam logic [2:0] CC_EQ = 3'b001;
  localparam logic [2:0] CC_GT = 3'b010;
  localparam logic [2:0] CC_LT = 3'b011;
  localparam logic [2:0] CC_GE = 3'b100;
  localparam logic [2:0] CC_LE = 3'b101;
  localparam logic [2:0] CC_OV = 3'b110;
  localparam logic [2:0] CC_UN = 3'b111;

  // Which flag bits an opcode is allowed to write; others hold.
  function automatic logic [FLAGS_W-1:0] flag_mask(input logic [3:0] op);
    logic [FLAGS_W-1:0] m;
    m = '0;
    case (op)
      OP_ADD, OP_SUB:         m = '1;
      OP_XOR, OP_SLL,
      OP_SRA, OP_ROR:         m[FLG_Z] = 1'b1;
      default:                m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/flag_branch_unit_cond_eval.sv
// Combinational branch condition evaluator against a {Z,V,N} flag vector.
module cond_eval
  import wisc_pkg::*;
(
  input  logic [2:0]         cond,
  input  logic [FLAGS_W-1:0] flags,
  output logic               taken
);

  logic z, v, n;
  assign z = flags[FLG_Z];
  assign v = flags[FLG_V];
  assign n = flags[FLG_N];

  always_comb begin
    taken = 1'b0;
    case (cond)
      CC_NE: taken = !z;
      CC_EQ: taken = z;
      CC_GT: taken = !z && !n;
      CC_LT: taken = n;
      CC_GE: taken = z || (!z && !n);
      CC_LE: taken = n || z;
      CC_OV: taken = v;
      CC_UN: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_branch_unit.sv
// Flag register fed by ALU results plus registered conditional-branch resolve.
// Build option FLAG_BYPASS_EN: same-cycle branches see the next-state flags.
module flag_branch_unit
  import wisc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int OP_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               alu_valid,
  input  logic [OP_W-1:0]    alu_op,
  input  logic [DATA_W-1:0]  alu_out,
  input  logic               alu_ovfl,
  input  logic               stall,
  input  logic               flush,
  input  logic               br_valid,
  input  logic [2:0]         br_cond,
  output logic [FLAGS_W-1:0] flags,
  output logic               br_taken,
  output logic               br_resolved
);

  logic               alu_acc, br_acc, cond_taken;
  logic [FLAGS_W-1:0] mask, new_flags, flags_nxt, eval_flags;

  assign alu_acc = alu_valid && !stall && !flush;
  assign br_acc  = br_valid && !stall && !flush;
  assign mask    = flag_mask(4'(alu_op));

  always_comb begin
    new_flags        = '0;
    new_flags[FLG_Z] = (alu_out == '0);
    new_flags[FLG_V] = alu_ovfl;
    new_flags[FLG_N] = alu_out[DATA_W-1];
  end

  assign flags_nxt = alu_acc ? ((mask & new_flags) | (~mask & flags)) : flags;

`ifdef FLAG_BYPASS_EN
  assign eval_flags = flags_nxt;
`else
  assign eval_flags = flags;
`endif

  cond_eval u_cond_eval (
    .cond  (br_cond),
    .flags (eval_flags),
    .taken (cond_taken)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags       <= '0;
      br_taken    <= 1'b0;
      br_resolved <= 1'b0;
    end else begin
      flags <= flags_nxt;
      // flush outranks stall: a squashed branch leaves not-taken behind
      if (flush) begin
        br_taken    <= 1'b0;
        br_resolved <= 1'b0;
      end else if (br_acc) begin
        br_taken    <= cond_taken;
        br_resolved <= 1'b1;
      end else begin
        br_resolved <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed bench for flag_branch_unit with hand-computed expectations.
module tb_flag_branch_unit;
  import wisc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, alu_ovfl, stall, flush, br_valid;
  logic [3:0]  alu_op;
  logic [15:0] alu_out;
  logic [2:0]  br_cond;
  logic [2:0]  flags;
  logic        br_taken, br_resolved;

  int total = 0;
  int bad   = 0;

`ifdef FLAG_BYPASS_EN
  localparam logic BYP_EXP = 1'b1;
`else
  localparam logic BYP_EXP = 1'b0;
`endif

  always #5 clk = ~clk;

  flag_branch_unit #(.DATA_W(16), .OP_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .alu_valid(alu_valid), .alu_op(alu_op),
    .alu_out(alu_out), .alu_ovfl(alu_ovfl), .stall(stall), .flush(flush),
    .br_valid(br_valid), .br_cond(br_cond), .flags(flags),
    .br_taken(br_taken), .br_resolved(br_resolved)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    alu_valid = 0; alu_op = OP_RED; alu_out = '0; alu_ovfl = 0;
    stall = 0; flush = 0; br_valid = 0; br_cond = CC_NE;
  endtask

  // advance one edge, sample 1 time unit later, drop all strobes
  task automatic tick();
    @(posedge clk); #1;
    idle();
  endtask

  task automatic alu(input logic [3:0] op, input logic [15:0] r, input logic ov);
    alu_valid = 1; alu_op = op; alu_out = r; alu_ovfl = ov;
  endtask

  task automatic br(input logic [2:0] c);
    br_valid = 1; br_cond = c;
  endtask

  initial begin
    idle();
    rst_n = 0;
    #12;
    chk("rst_flags", 32'(flags), 0);
    chk("rst_taken", 32'(br_taken), 0);
    chk("rst_res",   32'(br_resolved), 0);
    @(negedge clk); rst_n = 1;

    // ADD zero -> Z only, then EQ taken
    alu(OP_ADD, 16'h0000, 0); tick();
    chk("add0_flags", 32'(flags), 3'b100);
    br(CC_EQ); tick();
    chk("eq_taken", 32'(br_taken), 1);
    chk("eq_res",   32'(br_resolved), 1);
    tick();
    chk("eq_res_drop",  32'(br_resolved), 0);
    chk("eq_taken_hold", 32'(br_taken), 1);

    // SUB negative with overflow, then XOR zero writes only Z
    alu(OP_SUB, 16'h8000, 1); tick();
    chk("sub_flags", 32'(flags), 3'b011);
    alu(OP_XOR, 16'h0000, 0); tick();
    chk("xor_flags", 32'(flags), 3'b111);
    br(CC_LT); tick();
    chk("lt_taken", 32'(br_taken), 1);
    chk("lt_res",   32'(br_resolved), 1);
    br(CC_OV); tick();
    chk("ov_taken", 32'(br_taken), 1);
    br(CC_GT); tick();
    chk("gt_taken", 32'(br_taken), 0);
    chk("gt_res",   32'(br_resolved), 1);

    // non-writers leave flags alone
    alu(OP_SUB, 16'h8000, 1); tick();
    alu(OP_RED, 16'h0000, 0); tick();
    chk("red_flags", 32'(flags), 3'b011);
    alu(OP_PADDSB, 16'h0000, 0); tick();
    chk("paddsb_flags", 32'(flags), 3'b011);
    alu(4'b1010, 16'h0000, 0); tick();
    chk("op1xxx_flags", 32'(flags), 3'b011);

    // stall freezes, flush squashes
    br(CC_UN); tick();
    chk("un_taken", 32'(br_taken), 1);
    for (int i = 0; i < 2; i++) begin
      alu(OP_ADD, 16'h0000, 0); br(CC_NE); stall = 1; tick();
      chk("stall_flags", 32'(flags), 3'b011);
      chk("stall_taken", 32'(br_taken), 1);
      chk("stall_res",   32'(br_resolved), 0);
    end
    alu(OP_ADD, 16'h0000, 0); br(CC_UN); stall = 1; flush = 1; tick();
    chk("flush_taken", 32'(br_taken), 0);
    chk("flush_res",   32'(br_resolved), 0);
    chk("flush_flags", 32'(flags), 3'b011);

    // same-cycle writer and branch
    alu(OP_ADD, 16'h0001, 0); tick();
    chk("clr_flags", 32'(flags), 3'b000);
    alu(OP_ADD, 16'h0000, 0); br(CC_EQ); tick();
    chk("same_taken", 32'(br_taken), 32'(BYP_EXP));
    chk("same_res",   32'(br_resolved), 1);
    chk("same_flags", 32'(flags), 3'b100);

    // Z-only writers hold V/N across back-to-back updates
    alu(OP_ADD, 16'h8000, 1); tick();
    alu(OP_SLL, 16'h1234, 0); tick();
    chk("sll_flags", 32'(flags), 3'b011);
    alu(OP_ROR, 16'h0000, 0); tick();
    chk("ror_flags", 32'(flags), 3'b111);
    alu(OP_SRA, 16'h8000, 0); tick();
    chk("sra_flags", 32'(flags), 3'b011);
    br(CC_NE); tick();
    chk("ne_taken", 32'(br_taken), 1);
    br(CC_GE); tick();
    chk("ge_taken", 32'(br_taken), 0);
    br(CC_LE); tick();
    chk("le_taken", 32'(br_taken), 1);

    // async reset while a resolution is visible
    br(CC_UN); tick();
    chk("pre_rst_res", 32'(br_resolved), 1);
    #2 rst_n = 0;
    #1;
    chk("arst_res",   32'(br_resolved), 0);
    chk("arst_taken", 32'(br_taken), 0);
    chk("arst_flags", 32'(flags), 0);
    @(negedge clk); rst_n = 1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
